// File: rtl/regfile_pkg.sv
// Shared defaults and packed-port helpers for the multi-port register file.
package regfile_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_DEPTH      = 32;

    // Base bit index of port `port` inside a bus that packs `width`-bit fields.
    function automatic int slice_base(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read, write and issue bundle between decode/writeback and the register file.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 2
);
    localparam int AW = $clog2(DEPTH);

    logic [NUM_WRITE-1:0]            we;
    logic [NUM_WRITE*AW-1:0]         wr_addr;
    logic [NUM_WRITE*DATA_WIDTH-1:0] wr_data;
    logic [NUM_READ*AW-1:0]          rd_addr;
    logic [NUM_READ*DATA_WIDTH-1:0]  rd_data;
    logic                            issue_valid;
    logic [AW-1:0]                   issue_addr;
    logic [NUM_READ-1:0]             rd_busy;

    modport master (
        output we, wr_addr, wr_data, rd_addr, issue_valid, issue_addr,
        input  rd_data, rd_busy
    );

    modport slave (
        input  we, wr_addr, wr_data, rd_addr, issue_valid, issue_addr,
        output rd_data, rd_busy
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: issue claims a destination, writeback releases it.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int NUM_READ  = 2,
    parameter int NUM_WRITE = 2,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_WRITE-1:0]    we,
    input  logic [NUM_WRITE*AW-1:0] wr_addr,
    input  logic [NUM_READ*AW-1:0]  rd_addr,
    input  logic                    issue_valid,
    input  logic [AW-1:0]           issue_addr,
    output logic [NUM_READ-1:0]     rd_busy
);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] clear_mask;
    logic [DEPTH-1:0] set_mask;
    logic [AW-1:0]    wa [NUM_WRITE];
    logic [AW-1:0]    ra [NUM_READ];

    for (genvar k = 0; k < NUM_WRITE; k++) begin : g_wa
        assign wa[k] = wr_addr[slice_base(k, AW) +: AW];
    end

    for (genvar j = 0; j < NUM_READ; j++) begin : g_ra
        assign ra[j] = rd_addr[slice_base(j, AW) +: AW];
    end

    always_comb begin
        clear_mask = '0;
        for (int k = 0; k < NUM_WRITE; k++) begin
            if (we[k]) begin
                clear_mask[wa[k]] = 1'b1;
            end
        end
    end

    always_comb begin
        set_mask = '0;
        if (issue_valid && !(ZERO_REG != 0 && issue_addr == '0)) begin
            set_mask[issue_addr] = 1'b1;
        end
    end

    // Set is applied after clear so a newly issued producer supersedes a retiring one.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            busy <= (busy & ~clear_mask) | set_mask;
        end
    end

    always_comb begin
        rd_busy = '0;
        for (int j = 0; j < NUM_READ; j++) begin
            if (BYPASS != 0) begin
                rd_busy[j] = busy[ra[j]] & ~clear_mask[ra[j]];
            end else begin
                rd_busy[j] = busy[ra[j]];
            end
            if (ZERO_REG != 0 && ra[j] == '0) begin
                rd_busy[j] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised N-read/M-write register file with optional x0, write bypass and busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input logic         clk,
    input logic         reset,
    regfile_mp_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] regs    [DEPTH];
    logic [AW-1:0]         wa      [NUM_WRITE];
    logic [DATA_WIDTH-1:0] wd      [NUM_WRITE];
    logic [AW-1:0]         ra      [NUM_READ];
    logic [DATA_WIDTH-1:0] rd_word [NUM_READ];

    for (genvar k = 0; k < NUM_WRITE; k++) begin : g_wr
        assign wa[k] = bus.wr_addr[slice_base(k, AW) +: AW];
        assign wd[k] = bus.wr_data[slice_base(k, DATA_WIDTH) +: DATA_WIDTH];
    end

    for (genvar j = 0; j < NUM_READ; j++) begin : g_rd
        assign ra[j] = bus.rd_addr[slice_base(j, AW) +: AW];
        assign bus.rd_data[slice_base(j, DATA_WIDTH) +: DATA_WIDTH] = rd_word[j];
    end

    // Ports are walked in ascending order, so the highest-index writer lands last.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_WRITE; k++) begin
                if (bus.we[k] && !(ZERO_REG != 0 && wa[k] == '0)) begin
                    regs[wa[k]] <= wd[k];
                end
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NUM_READ; j++) begin
            rd_word[j] = regs[ra[j]];
            if (BYPASS != 0) begin
                for (int k = 0; k < NUM_WRITE; k++) begin
                    if (bus.we[k] && wa[k] == ra[j]) begin
                        rd_word[j] = wd[k];
                    end
                end
            end
            if (ZERO_REG != 0 && ra[j] == '0) begin
                rd_word[j] = '0;
            end
        end
    end

    regfile_scoreboard #(
        .DEPTH     (DEPTH),
        .NUM_READ  (NUM_READ),
        .NUM_WRITE (NUM_WRITE),
        .ZERO_REG  (ZERO_REG),
        .BYPASS    (BYPASS)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .we          (bus.we),
        .wr_addr     (bus.wr_addr),
        .rd_addr     (bus.rd_addr),
        .issue_valid (bus.issue_valid),
        .issue_addr  (bus.issue_addr),
        .rd_busy     (bus.rd_busy)
    );

endmodule
